// File: rtl/sweep_decoder_pkg.sv
// Shared constants for the sweep decoder: FSM state encoding, default
// parameters and the config-index width helper.
package sweep_decoder_pkg;

    localparam int DEF_SEL_W = 3;
    localparam int DEF_NUM_F = 3;
    localparam int DEF_DWELL = 50;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // A single function still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sweep_decoder_dwell_counter.sv
// Dwell timer for the sweep: counts held cycles of the current select and
// flags the last one. Clearing restarts the hold period.
module dwell_counter #(
    parameter int WIDTH = 6,
    parameter int TERM  = 49
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERM);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign tc = enable && (cnt_q == TC_VAL);

endmodule

// File: rtl/sweep_decoder.sv
// Select decoder with programmable Boolean function outputs, driven either
// directly or by an automatic dwell-timed sweep over every select value.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | mode sampled; direct decode or sweep start accepted
// ST_SWEEP | stepping select 0..max, each held DWELL cycles
// ST_DONE  | one-cycle completion pulse, outputs hold last value
module sweep_decoder
    import sweep_decoder_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    parameter int NUM_F = DEF_NUM_F,
    parameter int DWELL = DEF_DWELL
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic [SEL_W-1:0]              s_in,
    input  logic                          s_valid,
    input  logic                          start,
    input  logic                          cfg_we,
    input  logic [idx_width(NUM_F)-1:0]   cfg_idx,
    input  logic [2**SEL_W-1:0]           cfg_mask,
    output logic [2**SEL_W-1:0]           onehot_out,
    output logic [NUM_F-1:0]              f_out,
    output logic [SEL_W-1:0]              sel_out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int NUM_OUT = 2**SEL_W;
    localparam int IDX_W   = idx_width(NUM_F);
    localparam int CNT_W   = $clog2(DWELL + 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_d;
    logic               apply;
    logic               dwell_tc;
    logic               dwell_clear;
    logic [NUM_OUT-1:0] onehot_d;
    logic [NUM_F-1:0]   f_d;
    logic [NUM_OUT-1:0] mask_q [NUM_F];

    dwell_counter #(
        .WIDTH (CNT_W),
        .TERM  (DWELL - 1)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (dwell_clear),
        .enable (state_q == ST_SWEEP),
        .tc     (dwell_tc)
    );

    // Counter sits at zero outside SWEEP and restarts on each step.
    assign dwell_clear = (state_q != ST_SWEEP) || dwell_tc;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_out;
        apply   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!mode && s_valid) begin
                    sel_d = s_in;
                    apply = 1'b1;
                end else if (mode && start) begin
                    sel_d   = '0;
                    apply   = 1'b1;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (dwell_tc) begin
                    if (sel_out == {SEL_W{1'b1}}) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d = sel_out + SEL_W'(1);
                        apply = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Functions read the masks as they stand before this edge's write.
    always_comb begin
        onehot_d = NUM_OUT'(1) << sel_d;
        f_d      = '0;
        for (int i = 0; i < NUM_F; i++) begin
            f_d[i] = mask_q[i][sel_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_out    <= '0;
            onehot_out <= '0;
            f_out      <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= apply;
            busy      <= (state_d == ST_SWEEP);
            done      <= (state_d == ST_DONE);
            if (apply) begin
                sel_out    <= sel_d;
                onehot_out <= onehot_d;
                f_out      <= f_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_F; i++) begin
                mask_q[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_F; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    mask_q[i] <= cfg_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_sweep_decoder.sv
// Directed plus randomized bench for sweep_decoder (SEL_W=3, NUM_F=3, DWELL=4)
// against a mask-array reference model.
module tb_sweep_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] s_in = '0;
    logic       s_valid = 1'b0;
    logic       start = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [7:0] cfg_mask = '0;
    logic [7:0] onehot_out;
    logic [2:0] f_out;
    logic [2:0] sel_out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    logic [7:0] mdl_mask [3];

    sweep_decoder #(.SEL_W(3), .NUM_F(3), .DWELL(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .s_in       (s_in),
        .s_valid    (s_valid),
        .start      (start),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_mask   (cfg_mask),
        .onehot_out (onehot_out),
        .f_out      (f_out),
        .sel_out    (sel_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_f(input int s);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = mdl_mask[i][s];
        return r;
    endfunction

    function automatic logic [7:0] exp_onehot(input int s);
        return 8'(2 ** s);
    endfunction

    task automatic write_mask(input int idx, input logic [7:0] m);
        cfg_we = 1'b1;
        cfg_idx = 2'(idx);
        cfg_mask = m;
        tick();
        cfg_we = 1'b0;
        if (idx < 3) mdl_mask[idx] = m;
    endtask

    task automatic direct(input int s, input string tag);
        logic [2:0] ef;
        ef = exp_f(s);
        mode = 1'b0;
        s_in = 3'(s);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check({tag, "_onehot"}, 32'(onehot_out), 32'(exp_onehot(s)));
        check({tag, "_f"}, 32'(f_out), 32'(ef));
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        int s, wi, pulses, k;
        logic wr;
        logic [7:0] wm;
        logic [2:0] ef;
        logic seen_done;

        for (int i = 0; i < 3; i++) mdl_mask[i] = '0;

        // reset state
        #2;
        check("rst_onehot", 32'(onehot_out), 32'h00);
        check("rst_f", 32'(f_out), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(sel_out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        direct(5, "direct5");
        check("direct5_sel", 32'(sel_out), 32'd5);
        tick();
        check("direct5_pulse_end", 32'(out_valid), 32'd0);
        check("direct5_hold", 32'(onehot_out), 32'h20);

        // mask decode
        write_mask(0, 8'hAA);
        write_mask(1, 8'hF0);
        write_mask(2, 8'h81);
        write_mask(3, 8'h55);
        direct(7, "mask7");
        check("mask7_const", 32'(f_out), 32'b111);
        direct(0, "mask0");
        check("mask0_const", 32'(f_out), 32'b100);

        // randomized direct decodes with occasional coincident writes
        for (int n = 0; n < 24; n++) begin
            s = int'($urandom_range(7, 0));
            wr = 1'($urandom_range(1, 0));
            wi = int'($urandom_range(3, 0));
            wm = 8'($urandom);
            ef = exp_f(s);
            mode = 1'b0;
            s_in = 3'(s);
            s_valid = 1'b1;
            cfg_we = wr;
            cfg_idx = 2'(wi);
            cfg_mask = wm;
            tick();
            s_valid = 1'b0;
            cfg_we = 1'b0;
            if (wr && wi < 3) mdl_mask[wi] = wm;
            check("rnd_onehot", 32'(onehot_out), 32'(exp_onehot(s)));
            check("rnd_f", 32'(f_out), 32'(ef));
            check("rnd_sel", 32'(sel_out), 32'(s));
        end

        // sweep timing with ignored start / s_valid during the sweep
        mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (k = 0; k < 32; k++) begin
            if (k > 0) tick();
            if (k == 5) begin
                start = 1'b1;
                s_valid = 1'b1;
                s_in = 3'd2;
            end
            if (k == 21) begin
                start = 1'b0;
                s_valid = 1'b0;
            end
            if (out_valid) pulses++;
            check("sweep_sel", 32'(sel_out), 32'(k / 4));
            check("sweep_valid", 32'(out_valid), 32'((k % 4) == 0));
            check("sweep_busy", 32'(busy), 32'd1);
            check("sweep_done", 32'(done), 32'd0);
            check("sweep_f", 32'(f_out), 32'(exp_f(k / 4)));
            check("sweep_onehot", 32'(onehot_out), 32'(exp_onehot(k / 4)));
        end
        tick();
        check("sweep_end_done", 32'(done), 32'd1);
        check("sweep_end_busy", 32'(busy), 32'd0);
        check("sweep_end_sel", 32'(sel_out), 32'd7);
        check("sweep_end_valid", 32'(out_valid), 32'd0);
        check("sweep_pulses", 32'(pulses), 32'd8);
        mode = 1'b0;
        tick();
        check("sweep_done_once", 32'(done), 32'd0);
        check("sweep_hold_sel", 32'(sel_out), 32'd7);

        // write coinciding with the select-1 update
        write_mask(0, 8'h00);
        mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = 1'b0;
        repeat (3) tick();
        ef = exp_f(1);
        cfg_we = 1'b1;
        cfg_idx = 2'd0;
        cfg_mask = 8'hFF;
        tick();
        cfg_we = 1'b0;
        mdl_mask[0] = 8'hFF;
        check("simwr_sel1", 32'(sel_out), 32'd1);
        check("simwr_old_f0", 32'(f_out[0]), 32'(ef[0]));
        repeat (4) tick();
        check("simwr_sel2", 32'(sel_out), 32'd2);
        check("simwr_new_f0", 32'(f_out[0]), 32'(exp_f(2) >> 0) & 32'd1);
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("simwr_done_seen", 32'(seen_done), 32'd1);

        // mid-sweep reset at select 3
        write_mask(1, 8'hFF);
        write_mask(2, 8'hFF);
        mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("mid_sel3", 32'(sel_out), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_onehot", 32'(onehot_out), 32'h00);
        check("mid_rst_f", 32'(f_out), 32'h0);
        check("mid_rst_sel", 32'(sel_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) mdl_mask[i] = '0;
        repeat (3) begin
            tick();
            check("mid_rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        mode = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("mid_rst_no_late_done", 32'(seen_done), 32'd0);
        check("mid_rst_idle_busy", 32'(busy), 32'd0);
        direct(7, "post_rst7");
        check("post_rst_masks_clear", 32'(f_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
